// File: rtl/cdc_xfer_arbiter.sv
// ============================================================================
//  Module      : cdc_xfer_arbiter
//  Description : Source-domain scheduler that shares one toggle-handshake
//                clock-domain-crossing channel between NUM_REQ requesters.
//                A round-robin arbiter picks one requester, latches its word
//                onto the channel and flips the request toggle. Completion
//                is detected when the synchronized ack toggle matches the
//                request toggle. One transfer is in flight at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1               single clock, rising edge
//    reset             in   1               synchronous, active-high
//    req               in   NUM_REQ         per-requester level request
//    req_data          in   NUM_REQ*DATA_W  word i at [i*DATA_W +: DATA_W]
//    grant             out  NUM_REQ         one-hot channel owner
//    done              out  NUM_REQ         one-hot completion pulse
//    busy              out  1               state is not IDLE
//    xfer_data         out  DATA_W          word presented to the crossing
//    xfer_req_tgl      out  1               request toggle to destination
//    xfer_ack_tgl_sync in   1               ack toggle, synchronized to clk
//    xfer_count        out  8               completed transfers (wraps)
//    timeout_err       out  1               sticky ack-timeout flag
// ----------------------------------------------------------------------------
//  Build option
//    CDC_XFER_ARB_TIMEOUT_EN : when defined, a wait counter runs in WAIT_ACK
//                              and timeout_err sets after TIMEOUT_CYCLES
//                              cycles without an ack. When undefined, no
//                              counter is built and timeout_err is tied low.
// ============================================================================
`default_nettype none

module cdc_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [DATA_W-1:0]         xfer_data,
    output logic                      xfer_req_tgl,
    input  logic                      xfer_ack_tgl_sync,
    output logic [7:0]                xfer_count,
    output logic                      timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [IDX_W:0] c_NUM_REQ = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W:0] c_ONE     = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LAUNCH   = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_owner;
    logic [NUM_REQ-1:0]    r_grant;
    logic [DATA_W-1:0]     r_xfer_data;
    logic                  r_req_tgl;
    logic [7:0]            r_count;

    logic [2*NUM_REQ-1:0]  w_req_dbl;
    logic [NUM_REQ-1:0]    w_req_rot;
    logic [IDX_W-1:0]      w_off;
    logic [IDX_W:0]        w_sum;
    logic [IDX_W-1:0]      w_sel;
    logic [NUM_REQ-1:0]    w_sel_onehot;
    logic [DATA_W-1:0]     w_sel_data;
    logic [IDX_W:0]        w_owner_inc;
    logic [IDX_W-1:0]      w_ptr_next;
    logic                  w_any_req;
    logic                  w_ack_match;

    // ------------------------------------------------------------------
    // Round-robin selection. The request vector is rotated so that bit 0
    // corresponds to the requester at r_ptr; the lowest set bit of the
    // rotated vector is the offset of the winner from r_ptr.
    // ------------------------------------------------------------------
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_req_rot = w_req_dbl[NUM_REQ-1:0];
    assign w_any_req = |req;

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Explicit modulo so non-power-of-two NUM_REQ wraps to 0 correctly.
    assign w_sum        = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sel        = (w_sum >= c_NUM_REQ) ? IDX_W'(w_sum - c_NUM_REQ)
                                               : w_sum[IDX_W-1:0];
    assign w_sel_onehot = NUM_REQ'(1) << w_sel;
    assign w_sel_data   = req_data[w_sel*DATA_W +: DATA_W];

    assign w_owner_inc  = {1'b0, r_owner} + c_ONE;
    assign w_ptr_next   = (w_owner_inc == c_NUM_REQ) ? '0
                                                     : w_owner_inc[IDX_W-1:0];

    // Ack parity only matters in WAIT_ACK; the FSM ignores it elsewhere.
    assign w_ack_match  = (xfer_ack_tgl_sync == r_req_tgl);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (w_ack_match) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: winner capture, toggle, pointer and completion counter.
    // xfer_data only loads in IDLE, so it is frozen for the whole
    // LAUNCH..DONE window regardless of req/req_data activity.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_xfer_data <= '0;
            r_req_tgl   <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_sel;
                        r_grant     <= w_sel_onehot;
                        r_xfer_data <= w_sel_data;
                    end
                end
                S_LAUNCH: begin
                    r_req_tgl <= ~r_req_tgl;
                end
                S_DONE: begin
                    // The just-served owner gets lowest priority next round.
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                    r_count <= r_count + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional ack timeout monitor
    // ------------------------------------------------------------------
`ifdef CDC_XFER_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                           ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] c_TMO     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_TMO_M1  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    // Counter is cleared in LAUNCH (entry to WAIT_ACK) and saturates at
    // TIMEOUT_CYCLES so a very long wait never wraps. The flag is sticky;
    // the FSM keeps waiting and a late ack still completes normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT_ACK && !w_ack_match) begin
                if (r_wait_cnt != c_TMO) begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                end
                if (r_wait_cnt == c_TMO_M1) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Keeps TIMEOUT_CYCLES referenced when the monitor is compiled out.
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign timeout_err  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign grant        = r_grant;
    assign done         = (r_state == S_DONE) ? r_grant : '0;
    assign busy         = (r_state != S_IDLE);
    assign xfer_data    = r_xfer_data;
    assign xfer_req_tgl = r_req_tgl;
    assign xfer_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cdc_xfer_arbiter.sv
// ============================================================================
//  Module      : tb_cdc_xfer_arbiter
//  Description : Self-checking bench for cdc_xfer_arbiter (NUM_REQ=4,
//                DATA_W=8). Table-driven cycle vectors plus hand-written
//                multi-cycle sequences for fairness, data hold, counter
//                wrap, reset mid-transfer and ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_xfer_arbiter;

`ifdef CDC_XFER_ARB_TIMEOUT_EN
    localparam int c_TMO    = 16;
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam int c_TMO    = 255;
    localparam bit c_TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  xfer_data;
    logic        xfer_req_tgl;
    logic        xfer_ack_tgl_sync;
    logic [7:0]  xfer_count;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    logic       m_tgl;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (c_TMO)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_data          (req_data),
        .grant             (grant),
        .done              (done),
        .busy              (busy),
        .xfer_data         (xfer_data),
        .xfer_req_tgl      (xfer_req_tgl),
        .xfer_ack_tgl_sync (xfer_ack_tgl_sync),
        .xfer_count        (xfer_count),
        .timeout_err       (timeout_err)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        ack;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic [7:0]  xdata;
        logic        tgl;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer starting from IDLE with the winner's req already up.
    task automatic xfer(input logic [3:0] g, input logic [7:0] d,
                        input bit disturb);
        tick();
        check("xfer_grant", {grant, xfer_data, busy, xfer_req_tgl},
              {g, d, 1'b1, m_tgl});
        tick();
        m_tgl = ~m_tgl;
        check("xfer_launch", {xfer_req_tgl, busy, done}, {m_tgl, 1'b1, 4'b0000});
        if (disturb) begin
            req      = 4'b0000;
            req_data = 32'hFFFF_FFFF;
        end
        tick();
        check("xfer_wait", {grant, xfer_data, busy, done}, {g, d, 1'b1, 4'b0000});
        tick();
        xfer_ack_tgl_sync = m_tgl;
        tick();
        check("xfer_done", {done, grant, xfer_data}, {g, g, d});
        m_cnt = m_cnt + 8'd1;
        tick();
        check("xfer_idle", {busy, done, grant, xfer_count, xfer_data},
              {1'b0, 4'b0000, 4'b0000, m_cnt, d});
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        xfer_ack_tgl_sync = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_tgl = 1'b0;
        m_cnt = 8'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          req      data          ack   grant    done     busy  xdata  tgl   cnt
        tbl[0]  = '{4'b0010, 32'h0000_A500, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA5, 1'b0, 8'd0};
        tbl[1]  = '{4'b0000, 32'h0000_A500, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA5, 1'b1, 8'd0};
        tbl[2]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA5, 1'b1, 8'd0};
        tbl[3]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'hA5, 1'b1, 8'd0};
        tbl[4]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hA5, 1'b1, 8'd0};
        tbl[5]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b1, 8'd1};
        tbl[6]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b1, 8'd1};
        // spurious ack change while IDLE
        tbl[7]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b1, 8'd1};
        // ptr=2, only requester 0 asks -> wraps to 0
        tbl[8]  = '{4'b0001, 32'h0000_003C, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'h3C, 1'b1, 8'd1};
        // ack equals the old toggle during LAUNCH: must not complete
        tbl[9]  = '{4'b0001, 32'h0000_003C, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h3C, 1'b0, 8'd1};
        tbl[10] = '{4'b0000, 32'h0000_003C, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h3C, 1'b0, 8'd1};
        tbl[11] = '{4'b0000, 32'h0000_003C, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h3C, 1'b0, 8'd1};
        tbl[12] = '{4'b0000, 32'h0000_003C, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h3C, 1'b0, 8'd2};
        // ptr=1 with req 0011 -> requester 1, then ptr=2 -> requester 0
        tbl[13] = '{4'b0011, 32'h0000_2211, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'h22, 1'b0, 8'd2};
        tbl[14] = '{4'b0011, 32'h0000_2211, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'h22, 1'b1, 8'd2};
        tbl[15] = '{4'b0011, 32'h0000_2211, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'h22, 1'b1, 8'd2};
        tbl[16] = '{4'b0011, 32'h0000_2211, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h22, 1'b1, 8'd3};
        tbl[17] = '{4'b0011, 32'h0000_2211, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h11, 1'b1, 8'd3};
        tbl[18] = '{4'b0000, 32'h0000_2211, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h11, 1'b0, 8'd3};
        tbl[19] = '{4'b0000, 32'h0000_2211, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h11, 1'b0, 8'd3};
        tbl[20] = '{4'b0000, 32'h0000_2211, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0, 8'd4};

        req      = 4'b0000;
        req_data = 32'h0;
        do_reset();

        // Reset state
        check("reset_state",
              {grant, done, busy, xfer_data, xfer_req_tgl, xfer_count, timeout_err},
              {4'b0, 4'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});

        // Table-driven vectors: inputs before an edge, outputs after it
        for (int i = 0; i < 21; i++) begin
            req               = tbl[i].req;
            req_data          = tbl[i].data;
            xfer_ack_tgl_sync = tbl[i].ack;
            tick();
            check($sformatf("vec%0d", i),
                  {grant, done, busy, xfer_data, xfer_req_tgl, xfer_count},
                  {tbl[i].grant, tbl[i].done, tbl[i].busy, tbl[i].xdata,
                   tbl[i].tgl, tbl[i].cnt});
        end

        // Round-robin fairness with all four requesting
        req = 4'b0000;
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        xfer(4'b0001, 8'h11, 1'b0);
        xfer(4'b0010, 8'h22, 1'b0);
        xfer(4'b0100, 8'h33, 1'b0);
        xfer(4'b1000, 8'h44, 1'b0);
        xfer(4'b0001, 8'h11, 1'b0);

        // Data hold: req dropped and req_data changed during WAIT_ACK
        req = 4'b0100;
        xfer(4'b0100, 8'h33, 1'b1);

        // Counter wrap: run until the count goes 255 -> 0
        req_data = 32'h4433_2211;
        req      = 4'b0001;
        while (m_cnt != 8'hFF) begin
            xfer(4'b0001, 8'h11, 1'b0);
        end
        check("wrap_255", {24'h0, xfer_count}, {24'h0, 8'hFF});
        xfer(4'b0001, 8'h11, 1'b0);
        check("wrap_0", {24'h0, xfer_count}, {24'h0, 8'h00});

        // Reset mid-transfer with the request toggle at 1
        req = 4'b1000;
        tick();
        check("mid_grant", {grant, busy}, {4'b1000, 1'b1});
        tick();
        check("mid_tgl", {xfer_req_tgl, busy}, {1'b1, 1'b1});
        tick();
        reset             = 1'b1;
        xfer_ack_tgl_sync = 1'b0;
        tick();
        check("mid_reset",
              {grant, done, busy, xfer_data, xfer_req_tgl, xfer_count, timeout_err},
              {4'b0, 4'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0});
        reset = 1'b0;
        m_tgl = 1'b0;
        m_cnt = 8'd0;
        req   = 4'b1001;
        xfer(4'b0001, 8'h11, 1'b0);

        // Ack timeout: withhold ack in WAIT_ACK
        req = 4'b0001;
        tick();
        tick();
        m_tgl = ~m_tgl;
        check("tmo_launch", {xfer_req_tgl, busy}, {m_tgl, 1'b1});
        req = 4'b0000;
        repeat (15) tick();
        check("tmo_before", {31'h0, timeout_err}, {31'h0, 1'b0});
        tick();
        check("tmo_at", {31'h0, timeout_err}, {31'h0, c_TMO_EN});
        repeat (40) tick();
        check("tmo_still_wait", {busy, done, timeout_err}, {1'b1, 4'b0000, c_TMO_EN});
        xfer_ack_tgl_sync = m_tgl;
        tick();
        check("tmo_done", {done, timeout_err}, {4'b0001, c_TMO_EN});
        m_cnt = m_cnt + 8'd1;
        tick();
        check("tmo_after", {busy, xfer_count, timeout_err}, {1'b0, m_cnt, c_TMO_EN});
        do_reset();
        check("tmo_reset", {31'h0, timeout_err}, {31'h0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
